mem_arbiter: RTL

//  Shares one single-ported memory between the fetch port (instruction reads) and the

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// The arbiter uses the slave view; the environment (requesters plus memory) uses master.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // fetch port
    logic                      i_req_valid;
    logic [ADDR_WIDTH-1:0]     i_req_addr;
    logic                      i_req_ready;
    logic                      i_rsp_valid;
    logic [DATA_WIDTH-1:0]     i_rsp_data;
    // load/store port
    logic                      d_req_valid;
    logic [ADDR_WIDTH-1:0]     d_req_addr;
    logic                      d_req_we;
    logic [DATA_WIDTH-1:0]     d_req_wdata;
    logic [DATA_WIDTH/8-1:0]   d_req_wstrb;
    logic                      d_req_ready;
    logic                      d_rsp_valid;
    logic [DATA_WIDTH-1:0]     d_rsp_data;
    // memory port
    logic                      m_req_valid;
    logic                      m_req_ready;
    logic [ADDR_WIDTH-1:0]     m_addr;
    logic                      m_we;
    logic [DATA_WIDTH-1:0]     m_wdata;
    logic [DATA_WIDTH/8-1:0]   m_wstrb;
    logic                      m_rsp_valid;
    logic [DATA_WIDTH-1:0]     m_rsp_data;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output m_req_valid, m_addr, m_we, m_wdata, m_wstrb,
        input  m_req_ready, m_rsp_valid, m_rsp_data
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  m_req_valid, m_addr, m_we, m_wdata, m_wstrb,
        output m_req_ready, m_rsp_valid, m_rsp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports.
// Data has priority; after STARVE_LIMIT data grants with fetch waiting, fetch wins once.
// One transaction in flight at a time: IDLE (arbitrate) -> REQ (present) -> RSP (await).
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t                 state_q, state_d;
    owner_t                 owner_q;
    logic [CNT_WIDTH-1:0]   starve_cnt;
    logic                   grant_i, grant_d;

    // Next-state, arbitration and handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d         = state_q;
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        bus.m_req_valid = 1'b0;
        bus.i_rsp_valid = 1'b0;
        bus.d_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = bus.d_req_valid && (!bus.i_req_valid || starve_cnt != CNT_MAX);
                grant_i = bus.i_req_valid && !grant_d;
                if (grant_i || grant_d) state_d = REQ;
            end
            REQ: begin
                bus.m_req_valid = 1'b1;
                if (bus.m_req_ready) state_d = RSP;
            end
            RSP: begin
                if (bus.m_rsp_valid) begin
                    bus.i_rsp_valid = (owner_q == OWN_I);
                    bus.d_rsp_valid = (owner_q == OWN_D);
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset overrides a transaction in flight, so nothing may leak out while rst_n is low.
        if (!rst_n) begin
            grant_i         = 1'b0;
            grant_d         = 1'b0;
            bus.m_req_valid = 1'b0;
            bus.i_rsp_valid = 1'b0;
            bus.d_rsp_valid = 1'b0;
        end
        bus.i_req_ready = grant_i;
        bus.d_req_ready = grant_d;
        bus.i_rsp_data  = bus.i_rsp_valid ? bus.m_rsp_data : '0;
        bus.d_rsp_data  = bus.d_rsp_valid ? bus.m_rsp_data : '0;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture the winning request and maintain the fetch starvation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            starve_cnt  <= '0;
            bus.m_addr  <= '0;
            bus.m_we    <= 1'b0;
            bus.m_wdata <= '0;
            bus.m_wstrb <= '0;
        end else if (grant_d) begin
            owner_q     <= OWN_D;
            bus.m_addr  <= bus.d_req_addr;
            bus.m_we    <= bus.d_req_we;
            bus.m_wdata <= bus.d_req_wdata;
            bus.m_wstrb <= bus.d_req_we ? bus.d_req_wstrb : '0;
            if (bus.i_req_valid && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
        end else if (grant_i) begin
            owner_q     <= OWN_I;
            starve_cnt  <= '0;
            bus.m_addr  <= bus.i_req_addr;
            bus.m_we    <= 1'b0;
            bus.m_wdata <= '0;
            bus.m_wstrb <= '0;
        end else if (state_q == RSP && bus.m_rsp_valid) begin
            owner_q     <= OWN_NONE;
        end
    end
endmodule
